// File: rtl/shiftreg_pkg.sv
// Shared types and register map for the pushbutton shift-register scanner.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    UPDATE
  } state_e;

  localparam logic [1:0] REG_BUTTONS = 2'd0;
  localparam logic [1:0] REG_RAW     = 2'd1;
  localparam logic [1:0] REG_CHANGED = 2'd2;
  localparam logic [1:0] REG_IRQEN   = 2'd3;

  localparam int DATA_W = 32;

endpackage

// File: rtl/shiftreg_debounce.sv
// Per-bit scan-count debouncer: a bit toggles after DEBOUNCE_SCANS consecutive
// scans that disagree with it; update strobes once per completed scan.
module shiftreg_debounce
  import shiftreg_pkg::*;
#(
  parameter int NUM_BITS       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                update,
  input  logic [NUM_BITS-1:0] raw_next,
  output logic [NUM_BITS-1:0] buttons,
  output logic [NUM_BITS-1:0] change
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

  logic [CW-1:0] cnt [NUM_BITS];

  // A bit flips on the scan that would bring its counter to DEBOUNCE_SCANS.
  always_comb begin
    change = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      change[i] = update && (raw_next[i] != buttons[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buttons <= '0;
      for (int i = 0; i < NUM_BITS; i++) cnt[i] <= '0;
    end else if (update) begin
      for (int i = 0; i < NUM_BITS; i++) begin
        if (raw_next[i] == buttons[i]) begin
          cnt[i] <= '0;
        end else if (change[i]) begin
          cnt[i]     <= '0;
          buttons[i] <= ~buttons[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shiftreg_buttons.sv
// Pushbutton shift-register scanner with debounce and an Avalon-MM slave.
// Define SHIFTREG_IRQ_EN to add the irq port and the irq_enable register.
module shiftreg_buttons
  import shiftreg_pkg::*;
#(
  parameter int CLK_DIV        = 25,
  parameter int NUM_BITS       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              shiftreg_in,
  output logic              shiftreg_loadn,
  output logic              shiftreg_clk,
  input  logic [1:0]        address,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata
`ifdef SHIFTREG_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);

  state_e              state, state_d;
  logic [DW-1:0]       div, div_d;
  logic [BW-1:0]       bit_idx, bit_d;
  logic                sample, update, in_bit;
  logic [NUM_BITS-1:0] scan, raw, changed, buttons, change, clr;
  logic [DATA_W-1:0]   rd_mux;
  logic                unused_wdata;

  assign in_bit       = ~shiftreg_in;
  assign unused_wdata = ^(writedata >> NUM_BITS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LOAD;
      div     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_d;
      div     <= div_d;
      bit_idx <= bit_d;
    end
  end

  always_comb begin
    state_d = state;
    div_d   = div + 1'b1;
    bit_d   = bit_idx;
    sample  = 1'b0;
    update  = 1'b0;
    case (state)
      LOAD: begin
        if (div == DIV_LAST) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sample = (div == DIV_HALF);
        if (div == DIV_LAST) begin
          div_d = '0;
          if (bit_idx == BIT_LAST) state_d = UPDATE;
          else bit_d = bit_idx + 1'b1;
        end
      end
      UPDATE: begin
        update  = 1'b1;
        div_d   = '0;
        state_d = LOAD;
      end
      default: begin
        div_d   = '0;
        state_d = LOAD;
      end
    endcase
  end

  // Pins trail the FSM by one cycle, so the sample at div==CLK_DIV lands on
  // the last low cycle of shiftreg_clk, just before its rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shiftreg_loadn <= 1'b1;
      shiftreg_clk   <= 1'b0;
      scan           <= '0;
      raw            <= '0;
      changed        <= '0;
    end else begin
      shiftreg_loadn <= !(state == LOAD && div < DIV_HALF);
      shiftreg_clk   <= (state == SHIFT && div >= DIV_HALF);
      if (sample) scan <= (scan << 1) | NUM_BITS'(in_bit);
      if (update) raw <= scan;
      changed <= (changed & ~clr) | change;
    end
  end

  shiftreg_debounce #(
    .NUM_BITS      (NUM_BITS),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .update  (update),
    .raw_next(scan),
    .buttons (buttons),
    .change  (change)
  );

  assign clr = (write && address == REG_CHANGED) ? writedata[NUM_BITS-1:0] : '0;

`ifdef SHIFTREG_IRQ_EN
  logic [NUM_BITS-1:0] irq_enable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_enable <= '0;
      irq        <= 1'b0;
    end else begin
      if (write && address == REG_IRQEN) irq_enable <= writedata[NUM_BITS-1:0];
      irq <= |(changed & irq_enable);
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_BUTTONS: rd_mux = DATA_W'(buttons);
      REG_RAW:     rd_mux = DATA_W'(raw);
      REG_CHANGED: rd_mux = DATA_W'(changed);
`ifdef SHIFTREG_IRQ_EN
      REG_IRQEN:   rd_mux = DATA_W'(irq_enable);
`else
      REG_IRQEN:   rd_mux = '0;
`endif
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else if (read) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_shiftreg_buttons.sv
// Bench for shiftreg_buttons: a 16-bit parallel-in shift-register model on the
// pins, a table of scan vectors, and hand sequences for the multi-cycle cases.
module tb_shiftreg_buttons;
  import shiftreg_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        shiftreg_in = 1'b1;
  logic        loadn, sclk;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] readdata;
  logic [31:0] writedata = 32'd0;
`ifdef SHIFTREG_IRQ_EN
  logic        irq;
  localparam logic [31:0] IRQEN_MASK = 32'h0000_FFFF;
`else
  localparam logic [31:0] IRQEN_MASK = 32'h0000_0000;
`endif

  int total = 0;
  int bad = 0;
  int since_fall = 0;
  logic [31:0] exp_q[$];
  logic [15:0] pins = 16'hFFFF;
  logic [15:0] chip = 16'hFFFF;

  typedef struct {
    logic [15:0] pins;
    logic [31:0] raw;
    logic [31:0] btn;
    logic [31:0] chg;
  } vec_t;
  vec_t vecs[14];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  shiftreg_buttons dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .shiftreg_in   (shiftreg_in),
    .shiftreg_loadn(loadn),
    .shiftreg_clk  (sclk),
    .address       (address),
    .read          (read),
    .readdata      (readdata),
    .write         (write),
    .writedata     (writedata)
`ifdef SHIFTREG_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  // External 165-style register: parallel load while loadn low, shift on sclk rise.
  always @(posedge sclk or negedge loadn) begin
    if (!loadn) begin
      chip = pins;
      shiftreg_in = chip[15];
    end else begin
      #1;
      chip = {chip[14:0], 1'b1};
      shiftreg_in = chip[15];
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    since_fall++;
  endtask

  task automatic tick_to(input int n);
    while (since_fall < n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    read = 1'b1;
    tick();
    read = 1'b0;
    data = readdata;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address = addr;
    writedata = data;
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  // scoreboard
  task automatic check_reg(input logic [1:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    exp_q.push_back(exp);
    bus_read(addr, d);
    check(name, d, exp_q.pop_front());
  endtask

  task automatic wait_fall();
    logic prev;
    prev = loadn;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (prev && !loadn) begin
        since_fall = 0;
        return;
      end
      prev = loadn;
    end
    check("wait_fall_timeout", 32'd0, 32'd1);
  endtask

  // Starts just after a loadn fall, ends on the next one.
  task automatic measure_scan(input string tag);
    int   rise_at = -1;
    int   clk_first = -1;
    int   rises = 0;
    int   period = -1;
    logic prev_sclk = 1'b0;
    logic prev_ld = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      tick();
      if (loadn && rise_at < 0) rise_at = n;
      if (sclk && !prev_sclk) begin
        rises++;
        if (clk_first < 0) clk_first = n;
      end
      if (!loadn && prev_ld) begin
        period = n;
        break;
      end
      prev_sclk = sclk;
      prev_ld = loadn;
    end
    since_fall = 0;
    check({tag, "_loadn_rise"}, rise_at, 32'd25);
    check({tag, "_first_sclk_rise"}, clk_first, 32'd75);
    check({tag, "_sclk_rises"}, rises, 32'd16);
    check({tag, "_period"}, period, 32'd851);
  endtask

  initial begin
    vecs[0]  = '{16'h3CA5, 32'hC35A, 32'h0, 32'h0};
    vecs[1]  = '{16'h7FFF, 32'h8000, 32'h0, 32'h0};
    vecs[2]  = '{16'hFFFF, 32'h0000, 32'h0, 32'h0};
    vecs[3]  = '{16'hFFFE, 32'h0001, 32'h0, 32'h0};
    vecs[4]  = '{16'hFFFE, 32'h0001, 32'h0, 32'h0};
    vecs[5]  = '{16'hFFFE, 32'h0001, 32'h0, 32'h0};
    vecs[6]  = '{16'hFFFF, 32'h0000, 32'h0, 32'h0};
    vecs[7]  = '{16'hFFFE, 32'h0001, 32'h0, 32'h0};
    vecs[8]  = '{16'hFFFE, 32'h0001, 32'h0, 32'h0};
    vecs[9]  = '{16'hFFFE, 32'h0001, 32'h0, 32'h0};
    vecs[10] = '{16'hFFFE, 32'h0001, 32'h1, 32'h1};
    vecs[11] = '{16'hFFFC, 32'h0003, 32'h1, 32'h1};
    vecs[12] = '{16'hFFFC, 32'h0003, 32'h1, 32'h1};
    vecs[13] = '{16'hFFFC, 32'h0003, 32'h1, 32'h1};

    #12;
    check("reset_loadn", {31'd0, loadn}, 32'd1);
    check("reset_sclk", {31'd0, sclk}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    wait_fall();
    pins = vecs[0].pins;
    measure_scan("scan0");
    check_reg(REG_RAW, 32'h0, "scan0_raw");
    check_reg(REG_BUTTONS, 32'h0, "scan0_buttons");
    check_reg(REG_CHANGED, 32'h0, "scan0_changed");

    for (int k = 0; k < 14; k++) begin
      pins = (k < 13) ? vecs[k+1].pins : 16'hFFFC;
      wait_fall();
      check_reg(REG_RAW, vecs[k].raw, $sformatf("vec%0d_raw", k));
      check_reg(REG_BUTTONS, vecs[k].btn, $sformatf("vec%0d_buttons", k));
      check_reg(REG_CHANGED, vecs[k].chg, $sformatf("vec%0d_changed", k));
    end

    // Clear bit 0 on the exact UPDATE cycle that sets bit 1.
    tick_to(849);
    address = REG_CHANGED;
    writedata = 32'h1;
    write = 1'b1;
    tick();
    write = 1'b0;
    check_reg(REG_CHANGED, 32'h2, "set_wins_changed");
    check_reg(REG_BUTTONS, 32'h3, "bit1_buttons");
    check_reg(REG_RAW, 32'h3, "bit1_raw");

    address = REG_CHANGED;
    writedata = 32'h2;
    read = 1'b1;
    write = 1'b1;
    tick();
    read = 1'b0;
    write = 1'b0;
    check("rw_same_cycle_pre_data", readdata, 32'h2);
    tick();
    tick();
    check("readdata_hold", readdata, 32'h2);
    check_reg(REG_CHANGED, 32'h0, "w1c_changed");

    bus_write(REG_BUTTONS, 32'h0);
    bus_write(REG_RAW, 32'hFFFF_FFFF);
    check_reg(REG_RAW, 32'h3, "ro_raw");
    bus_write(REG_IRQEN, 32'hFFFF_FFFF);
    check_reg(REG_IRQEN, IRQEN_MASK, "irqen_rw");
    bus_write(REG_IRQEN, 32'h1);
    check_reg(REG_BUTTONS, 32'h3, "ro_buttons");

    // Reset during slot 7, high phase of shiftreg_clk.
    wait_fall();
    tick_to(435);
    check("pre_reset_sclk", {31'd0, sclk}, 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_reset_loadn", {31'd0, loadn}, 32'd1);
    check("mid_reset_sclk", {31'd0, sclk}, 32'd0);
    check("mid_reset_readdata", readdata, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;

    wait_fall();
    measure_scan("post_reset");
    check_reg(REG_RAW, 32'h3, "post_reset_raw");
    check_reg(REG_BUTTONS, 32'h0, "post_reset_buttons");
    check_reg(REG_CHANGED, 32'h0, "post_reset_changed");
    check_reg(REG_IRQEN, 32'h0, "post_reset_irqen");
    bus_write(REG_IRQEN, 32'h1);
    wait_fall();
    wait_fall();
    check_reg(REG_BUTTONS, 32'h0, "scan3_buttons");

    // Fourth identical scan: read straddles the UPDATE cycle.
    tick_to(849);
    address = REG_CHANGED;
    read = 1'b1;
    tick();
    check("update_edge_changed_pre", readdata, 32'h0);
`ifdef SHIFTREG_IRQ_EN
    check("irq_low_at_update", {31'd0, irq}, 32'd0);
`endif
    tick();
    read = 1'b0;
    check("update_edge_changed_post", readdata, 32'h3);
`ifdef SHIFTREG_IRQ_EN
    check("irq_rise", {31'd0, irq}, 32'd1);
`endif
    check_reg(REG_BUTTONS, 32'h3, "scan4_buttons");
`ifdef SHIFTREG_IRQ_EN
    check("irq_stays_high", {31'd0, irq}, 32'd1);
`endif
    bus_write(REG_CHANGED, 32'h1);
`ifdef SHIFTREG_IRQ_EN
    check("irq_same_cycle_as_clear", {31'd0, irq}, 32'd1);
    tick();
    check("irq_fall", {31'd0, irq}, 32'd0);
`endif
    check_reg(REG_CHANGED, 32'h2, "partial_clear_changed");
    bus_write(REG_CHANGED, 32'h2);
    check_reg(REG_CHANGED, 32'h0, "final_clear_changed");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
